// File: rtl/sim_exit_monitor_if.sv
// Snooped tohost write channel between the DUT memory port and the exit monitor.
// The monitor side never stalls; wr_ready is driven by the slave.
interface sim_exit_monitor_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
);
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  modport master (output wr_valid, output wr_addr, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_addr, input wr_data, output wr_ready);
endinterface

// File: rtl/sim_exit_monitor.sv
// Simulation exit monitor: decodes tohost writes, enforces a cycle budget, and
// holds a sticky done/pass/fail/timeout verdict. Optional reporting: SIM_EXIT_MONITOR_PRINT_EN.
module sim_exit_monitor #(
  parameter int                ADDR_W      = 32,
  parameter int                DATA_W      = 64,
  parameter logic [ADDR_W-1:0] TOHOST_ADDR = 32'h8000_1000,
  parameter int                CNT_W       = 64
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               arm,
  input  logic [CNT_W-1:0]   max_cycles,
  sim_exit_monitor_if.slave  wr,
  output logic               done,
  output logic               pass,
  output logic               fail,
  output logic               timeout,
  output logic [DATA_W-2:0]  exit_code,
  output logic [CNT_W-1:0]   cycles
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t            state;
  state_t            state_nxt;
  logic              hit;
  logic              term_hit;
  logic              expire;
  logic [DATA_W-2:0] code_in;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  assign wr.wr_ready = 1'b1;

  assign code_in  = wr.wr_data[DATA_W-1:1];
  assign hit      = wr.wr_valid && wr.wr_ready && (wr.wr_addr == TOHOST_ADDR);
  assign term_hit = hit && wr.wr_data[0];
  // An all-ones budget means unlimited; >= keeps a lowered budget from being skipped.
  assign expire   = (max_cycles != {CNT_W{1'b1}}) && (cycles >= max_cycles);

  always_ff @(posedge clock) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (arm) state_nxt = S_RUN;
      S_RUN:   if (term_hit || expire) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_DONE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Verdict and counter: a terminating hit outranks expiry, and the counter does
  // not advance on the terminating edge.
  always_ff @(posedge clock) begin
    if (!reset) begin
      done      <= 1'b0;
      pass      <= 1'b0;
      fail      <= 1'b0;
      timeout   <= 1'b0;
      exit_code <= '0;
      cycles    <= '0;
    end else if (state == S_RUN) begin
      if (term_hit) begin
        done      <= 1'b1;
        pass      <= (code_in == '0);
        fail      <= (code_in != '0);
        exit_code <= code_in;
      end else if (expire) begin
        done      <= 1'b1;
        fail      <= 1'b1;
        timeout   <= 1'b1;
        exit_code <= '0;
        cycles    <= max_cycles;
      end else begin
        cycles    <= sat_inc(cycles);
      end
    end
  end

`ifdef SIM_EXIT_MONITOR_PRINT_EN
  always @(posedge clock) begin
    if (reset) begin
      if (state == S_IDLE && arm)
        $display("[exit_monitor] armed");
      if (state == S_IDLE && hit && wr.wr_data != '0)
        $warning("[exit_monitor] tohost write 0x%0h ignored before arm", wr.wr_data);
      if (state == S_RUN && term_hit)
        $display("[exit_monitor] %s exit_code=%0d cycles=%0d",
                 (code_in == '0) ? "PASS" : "FAIL", code_in, cycles);
      else if (state == S_RUN && expire)
        $display("[exit_monitor] TIMEOUT exit_code=0 cycles=%0d", max_cycles);
    end
  end
`endif

endmodule
